// File: rtl/asym_width_fifo_pkg.sv
// Shared helpers for the asymmetric-width FIFO: clog2 and parameter legality checks.
package asym_width_fifo_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   function automatic bit ratio_legal(input int unsigned r);
      return (r == 1) || (r == 2) || (r == 4) || (r == 8);
   endfunction

   function automatic bit depth_legal(input int unsigned d);
      return (d >= 4) && (d <= 4096) && ((d & (d - 1)) == 0);
   endfunction

endpackage

// File: rtl/asym_width_fifo_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port (1-cycle latency).
module sdp_ram #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WIDTH = 64,
   parameter int unsigned AW    = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // No reset on storage or read data so the array maps onto block SRAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/asym_width_fifo.sv
// Wide-write / narrow-read FIFO: each accepted wide word is emitted as RATIO narrow lanes.
module asym_width_fifo
   import asym_width_fifo_pkg::*;
#(
   parameter int unsigned NARROW_W   = 16,
   parameter int unsigned RATIO      = 4,
   parameter int unsigned WIDE_DEPTH = 256,
   parameter int unsigned LSB_FIRST  = 1
) (
   input  logic                                  clk,
   input  logic                                  resetn,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   input  logic [NARROW_W*RATIO-1:0]             s_data,
   output logic                                  m_valid,
   input  logic                                  m_ready,
   output logic [NARROW_W-1:0]                   m_data,
   input  logic                                  flush,
   output logic [clog2(WIDE_DEPTH*RATIO):0]      level
);

   localparam int unsigned WIDE_W = NARROW_W * RATIO;
   localparam int unsigned AW     = clog2(WIDE_DEPTH);
   localparam int unsigned PTR_W  = AW + 1;
   localparam int unsigned LANE_W = (RATIO > 1) ? clog2(RATIO) : 1;
   localparam int unsigned LVL_W  = clog2(WIDE_DEPTH * RATIO) + 1;

   if (!ratio_legal(RATIO)) begin : g_bad_ratio
      $error("asym_width_fifo: RATIO must be 1, 2, 4 or 8");
   end
   if (!depth_legal(WIDE_DEPTH)) begin : g_bad_depth
      $error("asym_width_fifo: WIDE_DEPTH must be a power of two in 4..4096");
   end

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  pf_ptr;
   logic [PTR_W-1:0]  rel_ptr;
   logic [PTR_W-1:0]  wide_count_nxt;
   logic [LANE_W-1:0] lane;
   logic              pf_valid;
   logic [WIDE_W-1:0] ram_q;
   logic [WIDE_W-1:0] out_word;
   logic [WIDE_W-1:0] out_shift;
   logic              wr_fire;
   logic              rd_fire;
   logic              last_lane;
   logic              out_done;
   logic              out_free;
   logic              pf_move;
   logic              fetch;
   logic              ram_we;

   // Handshake strobes and prefetch control; ram_q acts as the prefetch register.
   always_comb begin
      wr_fire        = s_valid && s_ready;
      rd_fire        = m_valid && m_ready;
      last_lane      = (lane == LANE_W'(RATIO - 1));
      out_done       = rd_fire && last_lane;
      out_free       = !m_valid || out_done;
      pf_move        = pf_valid && out_free;
      fetch          = (wr_ptr != pf_ptr) && (!pf_valid || pf_move);
      ram_we         = wr_fire && resetn && !flush;
      wide_count_nxt = (wr_ptr + PTR_W'(wr_fire)) - (rel_ptr + PTR_W'(out_done));
      out_shift      = (LSB_FIRST != 0) ? (out_word >> NARROW_W) : (out_word << NARROW_W);
   end

   sdp_ram #(
      .DEPTH (WIDE_DEPTH),
      .WIDTH (WIDE_W),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (s_data),
      .re    (fetch),
      .raddr (pf_ptr[AW-1:0]),
      .rdata (ram_q)
   );

   // Pointers, lane sequencing, occupancy and the narrow output stage.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr   <= '0;
         pf_ptr   <= '0;
         rel_ptr  <= '0;
         lane     <= '0;
         pf_valid <= 1'b0;
         m_valid  <= 1'b0;
         level    <= '0;
         s_ready  <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         pf_ptr   <= '0;
         rel_ptr  <= '0;
         lane     <= '0;
         pf_valid <= 1'b0;
         m_valid  <= 1'b0;
         level    <= '0;
         s_ready  <= 1'b1;
      end else begin
         if (wr_fire)  wr_ptr  <= wr_ptr + PTR_W'(1);
         if (fetch)    pf_ptr  <= pf_ptr + PTR_W'(1);
         if (out_done) rel_ptr <= rel_ptr + PTR_W'(1);

         if (fetch)        pf_valid <= 1'b1;
         else if (pf_move) pf_valid <= 1'b0;

         if (rd_fire && !last_lane) begin
            out_word <= out_shift;
            lane     <= lane + LANE_W'(1);
         end else if (out_free) begin
            m_valid <= pf_valid;
            lane    <= '0;
            if (pf_valid) out_word <= ram_q;
         end

         level   <= level + LVL_W'(wr_fire ? RATIO : 0) - LVL_W'(rd_fire);
         // A slot is released only once its last lane has been consumed.
         s_ready <= (wide_count_nxt != PTR_W'(WIDE_DEPTH));
      end
   end

   if (LSB_FIRST != 0) begin : g_lsb
      assign m_data = out_word[NARROW_W-1:0];
   end else begin : g_msb
      assign m_data = out_word[WIDE_W-1 -: NARROW_W];
   end

endmodule

// File: doc/asym_width_fifo.md
ASYM_WIDTH_FIFO -- requirements
Module: asym_width_fifo

Interface
REQ-001 SHALL have parameter NARROW_W, default 16: read-side word width in bits.
REQ-002 SHALL have parameter RATIO, default 4: write/read width ratio; legal values 1, 2, 4, 8.
REQ-003 SHALL have parameter WIDE_DEPTH, default 256: capacity in wide words; power of two, 4..4096.
REQ-004 SHALL have parameter LSB_FIRST, default 1: 1 = lane 0 (bits NARROW_W-1:0) read first; 0 = most-significant lane read first.
REQ-005 SHALL have port clk  in  1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port resetn  in  1: reset, synchronous, active-low.
REQ-007 SHALL have port s_valid  in  1: write data valid.
REQ-008 SHALL have port s_ready  out  1: FIFO can accept a wide word.
REQ-009 SHALL have port s_data  in  NARROW_W*RATIO: wide write word.
REQ-010 SHALL have port m_valid  out  1: m_data holds a valid narrow word.
REQ-011 SHALL have port m_ready  in  1: consumer takes m_data.
REQ-012 SHALL have port m_data  out  NARROW_W: narrow read word.
REQ-013 SHALL have port flush  in  1: synchronous discard of all contents.
REQ-014 SHALL have port level  out  clog2(WIDE_DEPTH*RATIO)+1: occupancy in narrow words.

Function
REQ-015 Write accepted iff s_valid && s_ready at a clk edge; read consumed iff m_valid && m_ready.
REQ-016 s_ready SHALL be 1 iff wide_count < WIDE_DEPTH, where wide_count counts wide words written and not yet fully consumed (partially read word still occupies its slot).
REQ-017 Each accepted wide word SHALL emerge as exactly RATIO narrow words, lane order set by LSB_FIRST, word order FIFO.
REQ-018 Write-to-read latency: a word accepted into an empty FIFO at edge N SHALL give m_valid=1 with its first lane after edge N+2.
REQ-019 Throughput: with m_ready held 1, no m_valid bubble between consecutive wide words when the next word was accepted at least 2 cycles before the current word's last lane is consumed.
REQ-020 m_data and m_valid SHALL hold stable while m_valid && !m_ready.
REQ-021 level SHALL equal RATIO*wide_count minus lanes already consumed of the head word; updated the cycle after each accept/consume; simultaneous accept and consume net both.
REQ-022 Full: write attempted with s_ready=0 SHALL be ignored; no state change.
REQ-023 Empty: m_valid=0, m_ready ignored.
REQ-024 Simultaneous last-lane consume and write while full SHALL not accept the write (s_ready evaluated from registered count).
REQ-025 Pointers SHALL wrap modulo WIDE_DEPTH without loss or duplication.
REQ-026 flush=1 SHALL, at that edge, zero pointers, lane counter, count and output stage; any simultaneous write/read is discarded; flush wins over all.

Reset
REQ-027 resetn=0 at an edge: m_valid=0, level=0, pointers/lane counter=0, s_ready=0 while resetn=0.
REQ-028 s_ready SHALL go 1 on the first edge with resetn=1; reset mid-stream discards all data.
REQ-029 RAM contents not reset; m_data value undefined when m_valid=0.

Structure
REQ-030 Storage SHALL be one sub-module sdp_ram (simple dual-port, synchronous read, 1-cycle latency, WIDE_DEPTH x NARROW_W*RATIO) inferable to Gowin block SRAM.
REQ-031 Shared package SHALL hold the clog2 function and the legal-RATIO check; parameter violation SHALL be an elaboration error.
REQ-032 Top SHALL contain write pointer, prefetch pointer, release pointer, lane counter, prefetch/output registers and count logic.

Verification (NARROW_W=16, RATIO=4, WIDE_DEPTH=256)
REQ-033 Write 0x0004_0003_0002_0001, m_ready=1 -> m_valid after edge N+2; m_data 0x0001,0x0002,0x0003,0x0004 on 4 consecutive cycles; then level=0; with LSB_FIRST=0 order reversed.
REQ-034 256 writes, m_ready=0 -> level=1024, s_ready=0; 257th write ignored; after 3 reads s_ready still 0, after 4th read s_ready=1 next cycle, level=1020.
REQ-035 Stream 300 incrementing wide words, one write per 4 cycles, m_ready=1 -> 1200 narrow words in order across pointer wrap, no bubbles after the first.
REQ-036 Random s_valid/m_ready (50%) for 10000 cycles -> output matches scoreboard model; level never exceeds 1024.
REQ-037 flush with 10 words queued and a simultaneous write -> next cycle level=0, m_valid=0, written word not delivered.
REQ-038 resetn=0 for 1 cycle mid-stream -> m_valid=0, level=0, s_ready=0 during reset, s_ready=1 after; next written word delivered correctly.
